uart_tx_arbiter: RTL

Round-robin packet arbiter sharing one UART transmit path among `NUM_REQ` byte-stream requesters. Each requester offers bytes with valid/ready and flags the last byte of a message. A grant is held for the whole message, so messages never interleave on the wire. Sits between message producers (banner senders, status reporters) and the shared FIFO / `uart_tx` input.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the round-robin arbiter
// and the shared UART transmit path.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_last_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         tx_data_o;
  logic                          tx_valid_o;
  logic                          tx_ready_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_data_o, tx_valid_o, grant_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_data_o, tx_valid_o, grant_o, busy_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter: one requester owns the UART path from its first
// byte until its last byte is accepted, so messages never interleave.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]            state_r;
  logic [IDX_W-1:0]      grant_idx_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0]    grant_r;
  logic                  busy_r;
  logic [DATA_WIDTH-1:0] tx_data_r;
  logic                  tx_valid_r;

  logic                  found_s;
  logic [IDX_W-1:0]      pick_s;
  logic                  own_valid_s;
  logic                  own_last_s;
  logic [DATA_WIDTH-1:0] own_data_s;
  logic                  load_ok_s;
  logic                  accept_s;
  logic [NUM_REQ-1:0]    ready_s;

  // Index arithmetic modulo NUM_REQ; one extra bit absorbs the carry.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    sum = (sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum;
    return sum[IDX_W-1:0];
  endfunction

  // Round-robin search from rr_ptr; scanning farthest-first lets the nearest valid index win.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand    = wrap_add(rr_ptr_r, IDX_W'(k));
      pick_s  = bus.req_valid_i[cand] ? cand : pick_s;
      found_s = found_s | bus.req_valid_i[cand];
    end
  end

  // Select the current owner's byte stream.
  always_comb begin
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_data_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      own_valid_s = own_valid_s | ((grant_idx_r == IDX_W'(k)) & bus.req_valid_i[k]);
      own_last_s  = own_last_s  | ((grant_idx_r == IDX_W'(k)) & bus.req_last_i[k]);
      own_data_s  = own_data_s  | ((grant_idx_r == IDX_W'(k)) ?
                                   bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
  end

  // A byte may load whenever the output register is empty or draining this cycle.
  always_comb begin
    load_ok_s = !tx_valid_r || bus.tx_ready_i;
    accept_s  = (state_r == ST_LOCKED) && own_valid_s && load_ok_s;
    ready_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      ready_s[k] = (state_r == ST_LOCKED) && (grant_idx_r == IDX_W'(k)) && load_ok_s;
    end
  end

  // Arbitration FSM: lock on grant, release only when a last byte is accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r     <= ST_IDLE;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      grant_r     <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r     <= ST_LOCKED;
            grant_idx_r <= pick_s;
            grant_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (accept_s && own_last_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= wrap_add(grant_idx_r, IDX_W'(1));
            grant_r  <= '0;
            busy_r   <= 1'b0;
          end else begin
            state_r <= ST_LOCKED;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Output byte register: load on accept, otherwise empty once drained.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_data_r  <= '0;
      tx_valid_r <= 1'b0;
    end else if (accept_s) begin
      tx_data_r  <= own_data_s;
      tx_valid_r <= 1'b1;
    end else if (bus.tx_ready_i) begin
      tx_valid_r <= 1'b0;
    end else begin
      tx_valid_r <= tx_valid_r;
    end
  end

  assign bus.req_ready_o = ready_s;
  assign bus.tx_data_o   = tx_data_r;
  assign bus.tx_valid_o  = tx_valid_r;
  assign bus.grant_o     = grant_r;
  assign bus.busy_o      = busy_r;

endmodule
